// File: rtl/hud_score_bcd_if.sv
// Score-to-BCD port bundle: load/frame inputs toward the converter,
// display digits and status back toward the HUD renderer.
interface hud_score_bcd_if #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
);
  logic [WIDTH-1:0]  value;
  logic              load;
  logic              frame_start;
  logic [4*NDIG-1:0] digits;
  logic              ovf;
  logic              busy;
  logic              commit;

  modport master (
    output value, load, frame_start,
    input  digits, ovf, busy, commit
  );

  modport slave (
    input  value, load, frame_start,
    output digits, ovf, busy, commit
  );
endinterface

// File: rtl/hud_score_bcd.sv
// Serial double-dabble score converter; the visible digits only
// change on a frame_start so the renderer never shows a torn number.
module hud_score_bcd #(
  parameter int WIDTH    = 16,
  parameter int NDIG     = 5,
  parameter int BLANK_LZ = 1
) (
  input logic           clk,
  input logic           reset,
  hud_score_bcd_if.slave bus
);
  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             ovf_int;
  logic             pend_v;
  logic [WIDTH-1:0] pend;

  function automatic logic [BW-1:0] add3(
    input logic [BW-1:0] b
  );
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (r[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Overflow forces all nines; otherwise blank
  // zeros above the most significant nonzero digit.
  function automatic logic [BW-1:0] fmt(
    input logic [BW-1:0] b,
    input logic          o
  );
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    if (o) begin
      for (int i = 0; i < NDIG; i++)
        r[4*i +: 4] = 4'h9;
    end else if (BLANK_LZ != 0) begin
      for (int i = NDIG - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'h0)
          r[4*i +: 4] = 4'hF;
        else
          lead = 1'b0;
      end
    end
    return r;
  endfunction

  always_comb begin
    adj = add3(bcd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_int    <= 1'b0;
      pend_v     <= 1'b0;
      pend       <= '0;
      bus.digits <= fmt('0, 1'b0);
      bus.ovf    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.commit <= 1'b0;
    end else begin
      bus.commit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            shreg    <= bus.value;
            bcd      <= '0;
            cnt      <= '0;
            ovf_int  <= 1'b0;
            state    <= SHIFT;
            bus.busy <= 1'b1;
          end
        end
        SHIFT: begin
          bcd     <= {adj[BW-2:0], shreg[WIDTH-1]};
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          ovf_int <= ovf_int | adj[BW-1];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= WAIT;
          if (bus.load) begin
            pend   <= bus.value;
            pend_v <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.frame_start) begin
            bus.digits <= fmt(bcd, ovf_int);
            bus.ovf    <= ovf_int;
            bus.commit <= 1'b1;
            // A load in this cycle is newer than anything pending.
            if (bus.load || pend_v) begin
              shreg   <= bus.load ? bus.value : pend;
              bcd     <= '0;
              cnt     <= '0;
              ovf_int <= 1'b0;
              pend_v  <= 1'b0;
              state   <= SHIFT;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else if (bus.load) begin
            pend   <= bus.value;
            pend_v <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hud_score_bcd.sv
// Randomized bench for hud_score_bcd (NDIG=5 and NDIG=4 instances)
// against a decimal-arithmetic reference model.
module tb_hud_score_bcd;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   errs   = 0;
  int   checks = 0;

  hud_score_bcd_if #(.WIDTH(W), .NDIG(5)) bus5 ();
  hud_score_bcd_if #(.WIDTH(W), .NDIG(4)) bus4 ();

  assign bus4.value       = bus5.value;
  assign bus4.load        = bus5.load;
  assign bus4.frame_start = bus5.frame_start;

  hud_score_bcd #(.WIDTH(W), .NDIG(5), .BLANK_LZ(1)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  hud_score_bcd #(.WIDTH(W), .NDIG(4), .BLANK_LZ(1)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] fmtv(input int v, input int nd);
    logic [19:0] r;
    int          p;
    int          d;
    bit          lead;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    r = '0;
    if (v >= p) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    lead = 1'b1;
    p = p / 10;
    for (int i = nd - 1; i >= 0; i--) begin
      d = (v / p) % 10;
      p = p / 10;
      if (lead && d == 0 && i != 0) r[4*i +: 4] = 4'hF;
      else begin
        r[4*i +: 4] = d[3:0];
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  bit          m_busy, m_pv, m_commit, m_ovf4, m_en;
  int          m_cnt, m_cur, m_pend;
  logic [19:0] m_d5;
  logic [15:0] m_d4;

  task automatic model_step(input bit r, input bit l, input bit f, input int v);
    if (r) begin
      m_busy = 0; m_pv = 0; m_commit = 0; m_ovf4 = 0; m_cnt = 0;
      m_d5 = fmtv(0, 5);
      m_d4 = 16'(fmtv(0, 4));
      return;
    end
    m_commit = 0;
    if (!m_busy) begin
      if (l) begin
        m_busy = 1; m_cnt = W; m_cur = v;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (l) begin
        m_pend = v; m_pv = 1;
      end
    end else if (f) begin
      m_d5 = fmtv(m_cur, 5);
      m_d4 = 16'(fmtv(m_cur, 4));
      m_ovf4 = (m_cur > 9999);
      m_commit = 1;
      if (l) begin
        m_cur = v; m_cnt = W; m_pv = 0;
      end else if (m_pv) begin
        m_cur = m_pend; m_cnt = W; m_pv = 0;
      end else m_busy = 0;
    end else if (l) begin
      m_pend = v; m_pv = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit f, input int v);
    @(negedge clk);
    if (m_en) begin
      chk("d5",   32'(bus5.digits), 32'(m_d5));
      chk("ovf5", 32'(bus5.ovf),    32'(0));
      chk("bsy5", 32'(bus5.busy),   32'(m_busy));
      chk("cmt5", 32'(bus5.commit), 32'(m_commit));
      chk("d4",   32'(bus4.digits), 32'(m_d4));
      chk("ovf4", 32'(bus4.ovf),    32'(m_ovf4));
      chk("bsy4", 32'(bus4.busy),   32'(m_busy));
    end
    reset            = r;
    bus5.load        = l;
    bus5.frame_start = f;
    bus5.value       = W'(v);
    model_step(r, l, f, v);
    m_en = 1;
  endtask

  function automatic int pick_value();
    unique case ($urandom_range(0, 6))
      0: return 0;
      1: return 9999;
      2: return 10000;
      3: return 65535;
      4: return int'($urandom_range(0, 99));
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    m_en = 0;
    reset = 1'b1;
    bus5.load = 1'b0;
    bus5.frame_start = 1'b0;
    bus5.value = '0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_d5", 32'(bus5.digits), 32'h000F_FFF0);
    chk("rst_bsy", 32'(bus5.busy), 32'h0);

    cyc(0, 1, 0, 1234);
    repeat (29) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("dir1234", 32'(bus5.digits), 32'h000F_1234);
    chk("dir_cmt", 32'(bus5.commit), 32'h1);

    cyc(0, 1, 0, 12345);
    repeat (W + 2) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("dir_ovf4", 32'(bus4.digits), 32'h0000_9999);
    chk("dir_ovfb", 32'(bus4.ovf), 32'h1);

    // Pending overwrite, then reset mid-conversion with pending full.
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 8);
    cyc(0, 1, 0, 9);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_mid_b", 32'(bus5.busy), 32'h0);
    chk("rst_mid_d", 32'(bus5.digits), 32'h000F_FFF0);
    repeat (W + 4) cyc(0, 0, 1, 0);

    // Final-shift-cycle frame_start must be ignored.
    cyc(0, 1, 0, 42);
    repeat (W - 1) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("late_fs", 32'(bus5.commit), 32'h0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("d42", 32'(bus4.digits), 32'h0000_FF42);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 399) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 11) == 0),
          pick_value());
    end
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
